rs_issue_picker: RTL and testbench
==================================

Name: rs_issue_picker

Overview:
- Issue-side counterpart of the per-entry RS request/grant interface.
- Collects issue requests and issue packets from all entries of one reservation station.
- Grants at most one entry per cycle. The grant is the dealloc/issue grant returned to that entry.
- Registers the granted packet into a single-entry issue stage that feeds the execution unit, with backpressure.

Parameters:
- NUM_ENTRIES, 8, number of RS entries arbitrated (power of 2, >=2)
- ENT_ID_W, $clog2(NUM_ENTRIES), width of the entry index

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- nuke_rb1  input  t_nuke_pkt  pipeline nuke; .valid flushes
- oldest_robid  input  t_rob_id  oldest in-flight ROB id (used only with the optional feature)
- e_req_issue_rs1  input  [NUM_ENTRIES]  per-entry issue request
- e_issue_pkt_rs1  input  t_iss_pkt[NUM_ENTRIES]  per-entry issue packet
- e_gnt_issue_rs1  output  [NUM_ENTRIES]  per-entry grant, onehot0
- iss_valid_rs2  output  1  issue stage holds a valid packet
- iss_pkt_rs2  output  t_iss_pkt  issued packet
- iss_entry_rs2  output  ENT_ID_W  entry index the packet came from
- ex_stall_rs2  input  1  execution unit cannot accept this cycle

Behaviour:
- Reset (async, active-high): iss_valid_rs2=0, iss_pkt_rs2='0, iss_entry_rs2=0, rr_ptr=0. e_gnt_issue_rs1 is 0 while reset is asserted.
- Issue-stage state: EMPTY (iss_valid_rs2=0) or FULL (=1).
- Transfer to execution: occurs when FULL & ~ex_stall_rs2.
- stage_free = EMPTY | (FULL & ~ex_stall_rs2).
- Grant conditions, all evaluated in cycle rs1:
  - grant only when stage_free, ~nuke_rb1.valid, ~reset and at least one request is set;
  - grant is combinational from requests in the same cycle;
  - exactly one bit is set, and it is always a requesting entry.
- Selection (default, round-robin):
  - search starts at rr_ptr and moves upward with wrap (NUM_ENTRIES-1 -> 0);
  - the first requester found wins;
  - on a grant, rr_ptr <= winner+1 mod NUM_ENTRIES;
  - with no grant, rr_ptr holds.
- Capture and latency:
  - on a grant, the next edge loads iss_pkt_rs2 <= e_issue_pkt_rs1[winner], iss_entry_rs2 <= winner, iss_valid_rs2 <= 1;
  - latency is 1 cycle from grant to iss_valid_rs2.
- State transitions:
  - EMPTY -> FULL on grant;
  - FULL -> EMPTY on transfer with no new grant;
  - FULL -> FULL on transfer plus grant (back-to-back, one issue per cycle sustained);
  - FULL with stall: hold pkt/entry/valid unchanged and give no grant.
- Nuke: nuke_rb1.valid forces iss_valid_rs2 <= 0 at the next edge, regardless of stall or state, and suppresses the grant in that cycle. rr_ptr is unchanged. The packet payload may stay stale.
- Simultaneous requests from all entries: exactly one grant per cycle, and each entry is granted within NUM_ENTRIES cycles (starvation-free).
- iss_pkt_rs2 is stable whenever iss_valid_rs2 & ex_stall_rs2.
- Assertion (ASSERT builds): e_gnt_issue_rs1 is onehot0, and every grant bit is a subset of e_req_issue_rs1.

Optional Feature:
- Macro: RS_PICK_OLDEST_EN.
- Defined: selection becomes age-based instead of round-robin.
  - age[i] = e_issue_pkt_rs1[i].robid - oldest_robid, modulo ROB size, unsigned;
  - the requester with the smallest age wins;
  - ties are impossible (distinct robids), but any tie goes to the lowest index;
  - rr_ptr is not implemented (or held at 0);
  - all handshake, stall and nuke rules are identical.
- Undefined: round-robin as above, and oldest_robid is ignored.

Test Plan:
- Reset mid-operation: FULL with stall, assert reset -> iss_valid_rs2=0 immediately (async), rr_ptr=0, no grant; after release, requests at {2,5} -> grant entry 2.
- Round-robin: NUM_ENTRIES=8, all 8 requesting continuously, no stall -> grants 0,1,...,7,0 on consecutive cycles; iss_entry_rs2 follows one cycle later; iss_valid_rs2 stays 1.
- Wrap: rr_ptr=6, requests {1,3} -> grant 1, rr_ptr becomes 2; next cycle requests {1,3} -> grant 3.
- Backpressure: FULL with entry 4's packet, ex_stall_rs2=1 for 3 cycles with requests {0} -> no grants, packet and entry 4 held; on stall release, grant 0 the same cycle and entry 0's packet valid the next cycle.
- Nuke: FULL, ex_stall_rs2=1, nuke_rb1.valid=1 with requests {7} -> no grant that cycle, iss_valid_rs2=0 next cycle; following cycle grants 7.
- RS_PICK_OLDEST_EN: oldest_robid=30 (ROB size 32), requests {1 robid 2, 3 robid 31, 6 robid 30} -> grant 6, then 3, then 1.

Source files
------------

// File: rtl/rs_issue_picker.sv
// rs_issue_picker: picks one requesting reservation-station entry per cycle,
// returns the issue grant to it and registers its packet into a single-entry
// issue stage that feeds the execution unit, with backpressure and nuke.
// Selection is round-robin by default. Define RS_PICK_OLDEST_EN to select the
// requester whose robid is oldest relative to oldest_robid.

package rs_issue_pkg;

    localparam int ROB_SIZE = 32;
    localparam int ROB_ID_W = $clog2(ROB_SIZE);

    typedef logic [ROB_ID_W-1:0] t_rob_id;

    typedef struct packed {
        logic    valid;
        t_rob_id robid;
    } t_nuke_pkt;

    typedef struct packed {
        t_rob_id    robid;
        logic [6:0] opcode;
        logic [5:0] psrc1;
        logic [5:0] psrc2;
        logic [5:0] pdst;
    } t_iss_pkt;

endpackage

module rs_issue_picker
    import rs_issue_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int ENT_ID_W    = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  t_nuke_pkt              nuke_rb1,
    input  t_rob_id                oldest_robid,
    input  logic [NUM_ENTRIES-1:0] e_req_issue_rs1,
    input  t_iss_pkt               e_issue_pkt_rs1 [NUM_ENTRIES],
    output logic [NUM_ENTRIES-1:0] e_gnt_issue_rs1,
    output logic                   iss_valid_rs2,
    output t_iss_pkt               iss_pkt_rs2,
    output logic [ENT_ID_W-1:0]    iss_entry_rs2,
    input  logic                   ex_stall_rs2
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } t_stage_state;

    t_stage_state          state_q;
    t_stage_state          state_d;
    logic                  xfer;
    logic                  stage_free;
    logic                  grant_en;
    logic                  found;
    logic [ENT_ID_W-1:0]   winner;

    // The execution unit takes the held packet whenever it is not stalling.
    assign xfer       = (state_q == ST_FULL) && !ex_stall_rs2;
    assign stage_free = (state_q == ST_EMPTY) || xfer;
    assign grant_en   = stage_free && !nuke_rb1.valid && !reset && (|e_req_issue_rs1);

    // The nuke robid is informational only; a nuke flushes unconditionally.
    logic unused_nuke_robid;
    assign unused_nuke_robid = ^nuke_rb1.robid;

`ifdef RS_PICK_OLDEST_EN

    t_rob_id age;
    t_rob_id best_age;

    // Age-based pick: smallest (robid - oldest_robid) mod ROB size wins, ties to lowest index.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        winner   = '0;
        found    = 1'b0;
        best_age = '0;
        age      = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            age = e_issue_pkt_rs1[i].robid - oldest_robid;
            if (e_req_issue_rs1[i] && (!found || (age < best_age))) begin
                found    = 1'b1;
                best_age = age;
                winner   = ENT_ID_W'(i);
            end
        end
    end

`else

    logic [ENT_ID_W-1:0] rr_ptr_q;
    logic [ENT_ID_W-1:0] idx;
    logic                unused_oldest;

    assign unused_oldest = ^oldest_robid;

    // Round-robin pick: first requester at or above rr_ptr, wrapping past the top entry.
    always_comb begin
        winner = rr_ptr_q;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            idx = rr_ptr_q + ENT_ID_W'(k);
            if (!found && e_req_issue_rs1[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Advance the pointer past the winner on every grant; hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else if (grant_en) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            rr_ptr_q <= winner + 1'b1;
        end
    end

`endif

    // Onehot grant to the winning entry, only when the issue stage can take it.
    always_comb begin
        e_gnt_issue_rs1 = '0;
        if (grant_en) begin
            e_gnt_issue_rs1[winner] = 1'b1;
        end
    end

    // Issue-stage occupancy: nuke empties, grant fills, transfer without grant empties.
    always_comb begin
        state_d = state_q;
        if (nuke_rb1.valid) begin
            state_d = ST_EMPTY;
        end else if (grant_en) begin
            state_d = ST_FULL;
        end else if (xfer) begin
            state_d = ST_EMPTY;
        end
    end

    // Issue-stage occupancy register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the granted packet; it is held untouched while the stage is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the payload is reset too so the outputs are defined straight out of reset.
            iss_pkt_rs2   <= '0;
            iss_entry_rs2 <= '0;
        end else if (grant_en) begin
            iss_pkt_rs2   <= e_issue_pkt_rs1[winner];
            iss_entry_rs2 <= winner;
        end
    end

    assign iss_valid_rs2 = (state_q == ST_FULL);

`ifndef SYNTHESIS
    a_gnt_legal: assert property (@(posedge clk) disable iff (reset)
        $onehot0(e_gnt_issue_rs1) && ((e_gnt_issue_rs1 & ~e_req_issue_rs1) == '0));
`endif

endmodule

// File: tb/tb_rs_issue_picker.sv
// tb_rs_issue_picker: directed scenarios plus randomized traffic for
// rs_issue_picker, checked against a behavioural model of the picker.
// Honours RS_PICK_OLDEST_EN the same way the design does.

module tb_rs_issue_picker;
    import rs_issue_pkg::*;

    localparam int N = 8;
    localparam int W = $clog2(N);

    logic         clk;
    logic         reset;
    t_nuke_pkt    nuke_rb1;
    t_rob_id      oldest_robid;
    logic [N-1:0] req;
    t_iss_pkt     pkts [N];
    logic [N-1:0] gnt;
    logic         iss_valid;
    t_iss_pkt     iss_pkt;
    logic [W-1:0] iss_entry;
    logic         stall;

    rs_issue_picker #(.NUM_ENTRIES(N)) dut (
        .clk             (clk),
        .reset           (reset),
        .nuke_rb1        (nuke_rb1),
        .oldest_robid    (oldest_robid),
        .e_req_issue_rs1 (req),
        .e_issue_pkt_rs1 (pkts),
        .e_gnt_issue_rs1 (gnt),
        .iss_valid_rs2   (iss_valid),
        .iss_pkt_rs2     (iss_pkt),
        .iss_entry_rs2   (iss_entry),
        .ex_stall_rs2    (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model of the issue stage and arbitration pointer.
    bit       m_valid;
    int       m_entry;
    t_iss_pkt m_pkt;
    int       m_rr;

    logic [N-1:0] last_gnt;
    int           w;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Which requester should win this cycle, or -1 if none requests.
    function automatic int model_pick();
        int best = -1;
`ifdef RS_PICK_OLDEST_EN
        int best_age = 0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                int age = (int'(pkts[i].robid) - int'(oldest_robid) + ROB_SIZE) % ROB_SIZE;
                if (best < 0 || age < best_age) begin
                    best     = i;
                    best_age = age;
                end
            end
        end
`else
        for (int k = 0; k < N; k++) begin
            int j = (m_rr + k) % N;
            if (best < 0 && req[j]) best = j;
        end
`endif
        return best;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_entry = 0;
        m_pkt   = '0;
        m_rr    = 0;
    endtask

    task automatic rand_pkts();
        for (int i = 0; i < N; i++) begin
            pkts[i].robid  = t_rob_id'($urandom);
            pkts[i].opcode = 7'($urandom);
            pkts[i].psrc1  = 6'($urandom);
            pkts[i].psrc2  = 6'($urandom);
            pkts[i].pdst   = 6'($urandom);
        end
    endtask

    // One clock: check the grant mid-cycle, advance the model, check the stage after the edge.
    task automatic cycle(output int win);
        logic [N-1:0] exp_gnt;
        bit           free;
        @(negedge clk);
        free    = !m_valid || !stall;
        win     = (!nuke_rb1.valid && free) ? model_pick() : -1;
        exp_gnt = '0;
        if (win >= 0) exp_gnt[win] = 1'b1;
        last_gnt = gnt;
        check("gnt", 64'(gnt), 64'(exp_gnt));
        if (nuke_rb1.valid) begin
            m_valid = 1'b0;
        end else if (win >= 0) begin
            m_valid = 1'b1;
            m_entry = win;
            m_pkt   = pkts[win];
            m_rr    = (win + 1) % N;
        end else if (m_valid && !stall) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check("iss_valid", 64'(iss_valid), 64'(m_valid));
        if (m_valid) begin
            check("iss_entry", 64'(iss_entry), 64'(m_entry));
            check("iss_pkt", 64'(iss_pkt), 64'(m_pkt));
        end
    endtask

    initial begin
        reset          = 1'b1;
        nuke_rb1       = '0;
        oldest_robid   = '0;
        req            = '1;
        stall          = 1'b0;
        rand_pkts();
        model_reset();

        // Reset state: nothing valid, zeroed payload, no grant despite requests.
        #12;
        check("rst_valid", 64'(iss_valid), 64'd0);
        check("rst_entry", 64'(iss_entry), 64'd0);
        check("rst_pkt", 64'(iss_pkt), 64'd0);
        check("rst_gnt", 64'(gnt), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // All entries requesting continuously: one grant per cycle, in rotation.
        req = '1;
        for (int k = 0; k < 9; k++) begin
            rand_pkts();
            cycle(w);
`ifndef RS_PICK_OLDEST_EN
            check("rr_seq", 64'(last_gnt), 64'(1) << (k % N));
`endif
        end

        // Wrap: move the pointer to 6, then requests {1,3} grant 1 then 3.
        req = 8'b0010_0000;
        cycle(w);
        req = 8'b0000_1010;
        cycle(w);
`ifndef RS_PICK_OLDEST_EN
        check("wrap_first", 64'(last_gnt), 64'h02);
`endif
        cycle(w);
`ifndef RS_PICK_OLDEST_EN
        check("wrap_second", 64'(last_gnt), 64'h08);
`endif

        // Backpressure: hold entry 4 for three stalled cycles while entry 0 waits.
        req = 8'b0001_0000;
        cycle(w);
        req   = 8'b0000_0001;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle(w);
            check("bp_no_gnt", 64'(last_gnt), 64'h00);
            check("bp_entry4", 64'(iss_entry), 64'd4);
        end
        stall = 1'b0;
        cycle(w);
        check("bp_release_gnt", 64'(last_gnt), 64'h01);
        check("bp_release_entry", 64'(iss_entry), 64'd0);

        // Nuke while full and stalled: no grant, stage empties, then entry 7 is granted.
        req = 8'b0000_0100;
        cycle(w);
        req            = 8'b1000_0000;
        stall          = 1'b1;
        nuke_rb1.valid = 1'b1;
        cycle(w);
        check("nuke_no_gnt", 64'(last_gnt), 64'h00);
        check("nuke_empty", 64'(iss_valid), 64'd0);
        nuke_rb1.valid = 1'b0;
        cycle(w);
        check("post_nuke_gnt", 64'(last_gnt), 64'h80);

        // Reset mid-operation: full and stalled, reset clears the stage asynchronously.
        stall = 1'b0;
        req   = 8'b0000_1000;
        cycle(w);
        stall = 1'b1;
        req   = 8'b0010_0100;
        cycle(w);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_valid", 64'(iss_valid), 64'd0);
        check("async_rst_gnt", 64'(gnt), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        stall = 1'b0;
        oldest_robid    = 5'd10;
        pkts[2].robid   = 5'd10;
        pkts[5].robid   = 5'd13;
        cycle(w);
        check("rst_then_gnt2", 64'(last_gnt), 64'h04);

`ifdef RS_PICK_OLDEST_EN
        // Age order with wrap: robid 30 is oldest, then 31, then 2.
        oldest_robid  = 5'd30;
        pkts[1].robid = 5'd2;
        pkts[3].robid = 5'd31;
        pkts[6].robid = 5'd30;
        req = 8'b0100_1010;
        cycle(w);
        check("age_first", 64'(last_gnt), 64'h40);
        req = 8'b0000_1010;
        cycle(w);
        check("age_second", 64'(last_gnt), 64'h08);
        req = 8'b0000_0010;
        cycle(w);
        check("age_third", 64'(last_gnt), 64'h02);
`endif

        // Randomized traffic with stalls and occasional nukes.
        for (int k = 0; k < 400; k++) begin
            rand_pkts();
            req            = N'($urandom) & N'($urandom | $urandom);
            stall          = ($urandom_range(0, 3) == 0);
            nuke_rb1.valid = ($urandom_range(0, 19) == 0);
            nuke_rb1.robid = t_rob_id'($urandom);
            oldest_robid   = t_rob_id'($urandom);
            cycle(w);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
